cpu_bus_ctrl: RTL and testbench

- Synchronous control stage for the ADSP asynchronous memory-mapped bus.
- Sits directly upstream of cpu_databus_mg:
  - generates its dsp_iord_en / dsp_iowr_en controls;
  - supplies the read word on adsp_databus_rd;
  - consumes the captured write word from adsp_databus_wr.
- Converts the asynchronous DSP strobes into single-cycle register-file read/write transactions in the clk domain.

---
 rtl/cpu_bus_ctrl_if.sv | 38 +++
 rtl/cpu_bus_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_cpu_bus_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_ctrl_if.sv
// cpu_bus_ctrl_if: DSP async bus, register-file and databus-mux signals of cpu_bus_ctrl
interface cpu_bus_ctrl_if #(
   parameter int BIT_W  = 16,
   parameter int ADDR_W = 8
) ();
   logic              adsp_cs_n;
   logic              adsp_rd_n;
   logic              adsp_wr_n;
   logic [ADDR_W-1:0] adsp_addr;
   logic [BIT_W-1:0]  adsp_databus_wr;
   logic [BIT_W-1:0]  adsp_databus_rd;
   logic              dsp_iord_en;
   logic              dsp_iowr_en;
   logic              reg_wr_en;
   logic [ADDR_W-1:0] reg_wr_addr;
   logic [BIT_W-1:0]  reg_wr_data;
   logic              reg_rd_req;
   logic [ADDR_W-1:0] reg_rd_addr;
   logic [BIT_W-1:0]  reg_rd_data;
   logic              reg_rd_valid;
   logic              rd_timeout_err;

   modport slave (
      input  adsp_cs_n, adsp_rd_n, adsp_wr_n, adsp_addr, adsp_databus_wr,
      input  reg_rd_data, reg_rd_valid,
      output adsp_databus_rd, dsp_iord_en, dsp_iowr_en,
      output reg_wr_en, reg_wr_addr, reg_wr_data,
      output reg_rd_req, reg_rd_addr, rd_timeout_err
   );

   modport master (
      output adsp_cs_n, adsp_rd_n, adsp_wr_n, adsp_addr, adsp_databus_wr,
      output reg_rd_data, reg_rd_valid,
      input  adsp_databus_rd, dsp_iord_en, dsp_iowr_en,
      input  reg_wr_en, reg_wr_addr, reg_wr_data,
      input  reg_rd_req, reg_rd_addr, rd_timeout_err
   );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: turns async ADSP strobes into single-cycle register-file reads/writes in the clk domain
module cpu_bus_ctrl #(
   parameter int BIT_W      = 16,
   parameter int ADDR_W     = 8,
   parameter int SYNC_STG   = 2,
   parameter int RD_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   cpu_bus_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WR_ACT, RD_WAIT, RD_HOLD} state_t;

   logic [SYNC_STG-1:0] r_cs_n_sync;
   logic [SYNC_STG-1:0] r_rd_n_sync;
   logic [SYNC_STG-1:0] r_wr_n_sync;
   logic [ADDR_W-1:0]   r_addr_sync [SYNC_STG];
   logic [BIT_W-1:0]    r_data_sync [SYNC_STG];

   logic              w_s_cs_n;
   logic              w_s_rd_n;
   logic              w_s_wr_n;
   logic [ADDR_W-1:0] w_s_addr;
   logic [BIT_W-1:0]  w_s_data;
   logic              w_rd_any;
   logic              w_wr_any;
   logic              w_s_rd;
   logic              w_s_wr;

   logic              r_rd;
   logic              r_rd_d;
   logic              r_wr;
   logic              r_wr_d;
   logic [ADDR_W-1:0] r_addr_d;
   logic [BIT_W-1:0]  r_data_d;
   logic [ADDR_W-1:0] r_sh_addr;
   logic [BIT_W-1:0]  r_sh_data;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_to;

   logic              r_rd_req;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [BIT_W-1:0]  r_wr_data;
   logic [BIT_W-1:0]  r_rdata;
   logic              r_iord;
   logic              r_err;

   logic              w_rd_req;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [BIT_W-1:0]  w_wr_data;
   logic [BIT_W-1:0]  w_rdata;
   logic              w_iord;
   logic              w_err;

   assign w_s_cs_n = r_cs_n_sync[SYNC_STG-1];
   assign w_s_rd_n = r_rd_n_sync[SYNC_STG-1];
   assign w_s_wr_n = r_wr_n_sync[SYNC_STG-1];
   assign w_s_addr = r_addr_sync[SYNC_STG-1];
   assign w_s_data = r_data_sync[SYNC_STG-1];

   // read and write strobes active together are illegal and both get dropped
   assign w_rd_any = ~w_s_cs_n & ~w_s_rd_n;
   assign w_wr_any = ~w_s_cs_n & ~w_s_wr_n;
   assign w_s_rd   = w_rd_any & ~w_wr_any;
   assign w_s_wr   = w_wr_any & ~w_rd_any;

   assign w_to = r_cnt == CNT_W'(RD_TIMEOUT - 1);

   assign bus.adsp_databus_rd = r_rdata;
   assign bus.dsp_iord_en     = r_iord;
   assign bus.dsp_iowr_en     = r_wr;
   assign bus.reg_wr_en       = r_wr_en;
   assign bus.reg_wr_addr     = r_wr_addr;
   assign bus.reg_wr_data     = r_wr_data;
   assign bus.reg_rd_req      = r_rd_req;
   assign bus.reg_rd_addr     = r_rd_addr;
   assign bus.rd_timeout_err  = r_err;

   // equal-depth synchronizer chains keep strobes, address and data aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_n_sync <= '1;
         r_rd_n_sync <= '1;
         r_wr_n_sync <= '1;
         for (int i = 0; i < SYNC_STG; i++) begin
            r_addr_sync[i] <= '0;
            r_data_sync[i] <= '0;
         end
      end else begin
         r_cs_n_sync    <= {r_cs_n_sync[SYNC_STG-2:0], bus.adsp_cs_n};
         r_rd_n_sync    <= {r_rd_n_sync[SYNC_STG-2:0], bus.adsp_rd_n};
         r_wr_n_sync    <= {r_wr_n_sync[SYNC_STG-2:0], bus.adsp_wr_n};
         r_addr_sync[0] <= bus.adsp_addr;
         r_data_sync[0] <= bus.adsp_databus_wr;
         for (int i = 1; i < SYNC_STG; i++) begin
            r_addr_sync[i] <= r_addr_sync[i-1];
            r_data_sync[i] <= r_data_sync[i-1];
         end
      end
   end

   // registered strobes for edge detection, address/data kept in step, write shadow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd      <= 1'b0;
         r_rd_d    <= 1'b0;
         r_wr      <= 1'b0;
         r_wr_d    <= 1'b0;
         r_addr_d  <= '0;
         r_data_d  <= '0;
         r_sh_addr <= '0;
         r_sh_data <= '0;
      end else begin
         r_rd      <= w_s_rd;
         r_rd_d    <= r_rd;
         r_wr      <= w_s_wr;
         r_wr_d    <= r_wr;
         r_addr_d  <= w_s_addr;
         r_data_d  <= w_s_data;
         r_sh_addr <= r_wr ? r_addr_d : r_sh_addr;
         r_sh_data <= r_wr ? r_data_d : r_sh_data;
      end
   end

   // state, timeout counter and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rd_req  <= 1'b0;
         r_rd_addr <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_rdata   <= '0;
         r_iord    <= 1'b1;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rd_req  <= w_rd_req;
         r_rd_addr <= w_rd_addr;
         r_wr_en   <= w_wr_en;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
         r_rdata   <= w_rdata;
         r_iord    <= w_iord;
         r_err     <= w_err;
      end
   end

   // transaction sequencing: a strobe release always wins, valid beats timeout
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rd_req    = 1'b0;
      w_rd_addr   = r_rd_addr;
      w_wr_en     = 1'b0;
      w_wr_addr   = r_wr_addr;
      w_wr_data   = r_wr_data;
      w_rdata     = r_rdata;
      w_iord      = r_iord;
      w_err       = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_rd && !r_rd_d) begin
               w_state_nxt = RD_WAIT;
               w_rd_req    = 1'b1;
               w_rd_addr   = r_addr_d;
               w_cnt_nxt   = '0;
            end else if (r_wr && !r_wr_d) begin
               w_state_nxt = WR_ACT;
            end
         end
         WR_ACT: begin
            if (!r_wr) begin
               w_state_nxt = IDLE;
               w_wr_en     = 1'b1;
               w_wr_addr   = r_sh_addr;
               w_wr_data   = r_sh_data;
            end
         end
         RD_WAIT: begin
            if (!r_rd) begin
               w_state_nxt = IDLE;
            end else if (bus.reg_rd_valid) begin
               w_state_nxt = RD_HOLD;
               w_rdata     = bus.reg_rd_data;
               w_iord      = 1'b0;
            end else if (w_to) begin
               w_state_nxt = RD_HOLD;
               w_rdata     = '1;
               w_iord      = 1'b0;
               w_err       = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RD_HOLD: begin
            if (!r_rd) begin
               w_state_nxt = IDLE;
               w_iord      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: vector table, latency/reset sequences and randomized transactions for cpu_bus_ctrl
module tb_cpu_bus_ctrl;
   localparam int BIT_W      = 16;
   localparam int ADDR_W     = 8;
   localparam int SYNC_STG   = 2;
   localparam int RD_TIMEOUT = 15;
   localparam int K_WR       = 0;
   localparam int K_RD       = 1;
   localparam int K_ILL      = 2;
   localparam int K_NOCS     = 3;

   typedef struct {
      int          kind;
      logic [7:0]  addr;
      logic [15:0] data;
      int          len;
      int          dly;
      int          e_wr;
      int          e_req;
      int          e_err;
      int          e_rd;
      logic [15:0] e_bus;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cpu_bus_ctrl_if #(.BIT_W(BIT_W), .ADDR_W(ADDR_W)) b ();

   cpu_bus_ctrl #(
      .BIT_W(BIT_W), .ADDR_W(ADDR_W), .SYNC_STG(SYNC_STG), .RD_TIMEOUT(RD_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(b)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_seen, req_seen, err_seen, iord_lo_seen, iowr_seen, both_seen;
   int t_req, t_err, t_wr, t_iord_lo, t_iord_hi;
   logic [7:0]  wr_addr_seen, req_addr_seen;
   logic [15:0] wr_data_seen;
   int vdel = -1;
   int vt = 1000;
   logic [15:0] vword = '0;
   logic prev_iord = 1'b1;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_obs();
      wr_seen = 0; req_seen = 0; err_seen = 0; iord_lo_seen = 0; iowr_seen = 0; both_seen = 0;
      t_req = -1; t_err = -1; t_wr = -1; t_iord_lo = -1; t_iord_hi = -1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (b.reg_wr_en) begin
         wr_seen++; wr_addr_seen = b.reg_wr_addr; wr_data_seen = b.reg_wr_data; t_wr = cyc;
      end
      if (b.reg_rd_req) begin
         req_seen++; req_addr_seen = b.reg_rd_addr; t_req = cyc; vt = 0;
      end else if (vt < 1000) vt++;
      if (b.rd_timeout_err) begin
         err_seen++; t_err = cyc;
      end
      if (!b.dsp_iord_en) begin
         iord_lo_seen++;
         if (t_iord_lo < 0) t_iord_lo = cyc;
      end
      if (b.dsp_iord_en && !prev_iord) t_iord_hi = cyc;
      prev_iord = b.dsp_iord_en;
      if (b.dsp_iowr_en) iowr_seen++;
      if (b.reg_wr_en && b.reg_rd_req) both_seen++;
      b.reg_rd_valid = (vdel >= 0 && vt == vdel);
      b.reg_rd_data  = b.reg_rd_valid ? vword : ~vword;
   endtask

   task automatic idle_bus();
      b.adsp_cs_n = 1'b1; b.adsp_rd_n = 1'b1; b.adsp_wr_n = 1'b1;
   endtask

   // DSP-level rules: a write lands once; a read gets data if valid shows up within the window, else all-ones and an error
   function automatic vec_t model(input int kind, input logic [7:0] addr, input logic [15:0] data,
                                  input int len, input int dly);
      vec_t v;
      logic ok;
      ok      = (kind == K_RD) && dly >= 0 && dly < RD_TIMEOUT;
      v.kind  = kind; v.addr = addr; v.data = data; v.len = len; v.dly = dly;
      v.e_wr  = (kind == K_WR) ? 1 : 0;
      v.e_req = (kind == K_RD) ? 1 : 0;
      v.e_err = (kind == K_RD && !ok) ? 1 : 0;
      v.e_rd  = (kind == K_RD) ? 1 : 0;
      v.e_bus = ok ? data : 16'hFFFF;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      logic [15:0] bus_end;
      logic        iord_end;
      clear_obs();
      vdel = v.dly; vword = v.data;
      b.adsp_addr = v.addr; b.adsp_databus_wr = v.data;
      b.adsp_cs_n = (v.kind == K_NOCS);
      b.adsp_rd_n = !(v.kind == K_RD || v.kind == K_ILL);
      b.adsp_wr_n = !(v.kind == K_WR || v.kind == K_ILL || v.kind == K_NOCS);
      for (int i = 0; i < v.len; i++) begin
         step();
         if (v.kind == K_NOCS) b.adsp_wr_n = ~b.adsp_wr_n;
      end
      bus_end = b.adsp_databus_rd; iord_end = b.dsp_iord_en;
      idle_bus();
      b.adsp_addr = ~v.addr; b.adsp_databus_wr = ~v.data;
      repeat (12) step();
      vdel = -1;
      chk({tag, " wr_cnt"}, wr_seen, v.e_wr);
      chk({tag, " req_cnt"}, req_seen, v.e_req);
      chk({tag, " err_cnt"}, err_seen, v.e_err);
      chk({tag, " iowr_cycles"}, iowr_seen, (v.kind == K_WR) ? v.len : 0);
      chk({tag, " bus_driven"}, iord_lo_seen > 0, v.e_rd);
      chk({tag, " wr_and_req"}, both_seen, 0);
      chk({tag, " iord_final"}, b.dsp_iord_en, 1);
      if (v.e_wr != 0) begin
         chk({tag, " wr_addr"}, wr_addr_seen, v.addr);
         chk({tag, " wr_data"}, wr_data_seen, v.data);
      end
      if (v.e_req != 0) chk({tag, " rd_addr"}, req_addr_seen, v.addr);
      if (v.e_rd != 0) begin
         chk({tag, " bus_in_strobe"}, bus_end, v.e_bus);
         chk({tag, " iord_in_strobe"}, iord_end, 0);
         chk({tag, " bus_after"}, b.adsp_databus_rd, v.e_bus);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, c1;
      idle_bus();
      b.adsp_addr = '0; b.adsp_databus_wr = '0; b.reg_rd_valid = 1'b0; b.reg_rd_data = '0;
      clear_obs();
      tbl[0]  = '{K_WR,   8'h12, 16'hA5A5,  8, -1, 1, 0, 0, 0, 16'h0000};
      tbl[1]  = '{K_RD,   8'h34, 16'h5A5A, 20,  3, 0, 1, 0, 1, 16'h5A5A};
      tbl[2]  = '{K_RD,   8'h56, 16'h1234, 25, -1, 0, 1, 1, 1, 16'hFFFF};
      tbl[3]  = '{K_RD,   8'h78, 16'hBEEF, 25, 14, 0, 1, 0, 1, 16'hBEEF};
      tbl[4]  = '{K_RD,   8'h79, 16'hCAFE, 25, 15, 0, 1, 1, 1, 16'hFFFF};
      tbl[5]  = '{K_RD,   8'h44, 16'h7777,  4,  6, 0, 1, 0, 0, 16'h0000};
      tbl[6]  = '{K_ILL,  8'h55, 16'h1111,  8,  0, 0, 0, 0, 0, 16'h0000};
      tbl[7]  = '{K_NOCS, 8'h66, 16'h2222,  8, -1, 0, 0, 0, 0, 16'h0000};
      tbl[8]  = '{K_WR,   8'hFF, 16'hFFFF,  2, -1, 1, 0, 0, 0, 16'h0000};
      tbl[9]  = '{K_WR,   8'h00, 16'h0000,  3, -1, 1, 0, 0, 0, 16'h0000};
      tbl[10] = '{K_RD,   8'h00, 16'h8001, 20,  0, 0, 1, 0, 1, 16'h8001};

      repeat (3) step();
      chk("rst iord", b.dsp_iord_en, 1);
      chk("rst iowr", b.dsp_iowr_en, 0);
      chk("rst wr_en", b.reg_wr_en, 0);
      chk("rst rd_req", b.reg_rd_req, 0);
      chk("rst err", b.rd_timeout_err, 0);
      chk("rst bus", b.adsp_databus_rd, 0);
      chk("rst outs", {b.reg_wr_addr, b.reg_wr_data, b.reg_rd_addr}, 0);
      rst = 1'b0;
      repeat (2) step();

      for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // write release latency
      clear_obs();
      b.adsp_addr = 8'h21; b.adsp_databus_wr = 16'h0F0F;
      b.adsp_cs_n = 1'b0; b.adsp_wr_n = 1'b0;
      repeat (8) step();
      c1 = cyc;
      idle_bus();
      repeat (10) step();
      chk("wr latency", t_wr - c1, SYNC_STG + 2);
      chk("wr iowr cycles", iowr_seen, 8);

      // read request, data drive and release latency
      clear_obs();
      vdel = 3; vword = 16'h5A5A;
      b.adsp_addr = 8'h34;
      c0 = cyc;
      b.adsp_cs_n = 1'b0; b.adsp_rd_n = 1'b0;
      repeat (20) step();
      c1 = cyc;
      idle_bus();
      repeat (10) step();
      vdel = -1;
      chk("rd req latency", t_req - c0, SYNC_STG + 2);
      chk("rd drive latency", t_iord_lo - t_req, 4);
      chk("rd release latency", t_iord_hi - c1, SYNC_STG + 2);
      chk("rd bus kept", b.adsp_databus_rd, 16'h5A5A);

      // timeout distance from request
      clear_obs();
      b.adsp_cs_n = 1'b0; b.adsp_rd_n = 1'b0;
      repeat (25) step();
      idle_bus();
      repeat (10) step();
      chk("to distance", t_err - t_req, RD_TIMEOUT);
      chk("to pulses", err_seen, 1);
      chk("to drive same edge", t_iord_lo, t_err);
      chk("to bus", b.adsp_databus_rd, 16'hFFFF);

      // reset while holding read data on the bus
      clear_obs();
      vdel = 2; vword = 16'h1357;
      b.adsp_addr = 8'h3C;
      b.adsp_cs_n = 1'b0; b.adsp_rd_n = 1'b0;
      repeat (12) step();
      chk("hold before rst", b.dsp_iord_en, 0);
      rst = 1'b1;
      step();
      vdel = -1;
      chk("mid rst iord", b.dsp_iord_en, 1);
      chk("mid rst pulses", {b.reg_wr_en, b.reg_rd_req, b.rd_timeout_err, b.dsp_iowr_en}, 0);
      chk("mid rst bus", b.adsp_databus_rd, 0);
      idle_bus();
      step();
      rst = 1'b0;
      clear_obs();
      repeat (6) step();
      chk("post rst quiet", req_seen + wr_seen + iord_lo_seen, 0);
      apply(model(K_WR, 8'h01, 16'h0001, 6, -1), "post_rst_wr");

      for (int n = 0; n < 40; n++) begin
         int r, kind, len, dly;
         r    = int'($urandom_range(0, 9));
         kind = (r < 4) ? K_WR : (r < 8) ? K_RD : (r == 8) ? K_ILL : K_NOCS;
         len  = (kind == K_RD) ? SYNC_STG + RD_TIMEOUT + 3 + int'($urandom_range(0, 6))
                               : int'($urandom_range(2, 10));
         dly  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, RD_TIMEOUT + 4));
         apply(model(kind, 8'($urandom), 16'($urandom), len, dly), $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
